// File: rtl/iter_alu.sv
// Handshaked EX-stage execution unit: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide, with registered held results.
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             overflow,
   output logic             div_by_zero
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_PASS = 4'd0,  OP_AND  = 4'd1,  OP_OR   = 4'd2,  OP_XOR  = 4'd3;
   localparam logic [3:0] OP_ADDS = 4'd4,  OP_ADDU = 4'd5,  OP_SUBS = 4'd6,  OP_SUBU = 4'd7;
   localparam logic [3:0] OP_SHRL = 4'd8,  OP_SHLL = 4'd9,  OP_SHRA = 4'd10, OP_MULU = 4'd11;
   localparam logic [3:0] OP_MULS = 4'd12, OP_DIVU = 4'd13, OP_DIVS = 4'd14;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_reg, state_next;
   logic [3:0]       op_reg;
   logic [SHW-1:0]   cnt_reg;
   logic [WIDTH-1:0] acc_reg;     // product high half / partial remainder
   logic [WIDTH-1:0] mq_reg;      // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0] mag_reg;     // multiplicand or divisor magnitude
   logic             neg_lo_reg, neg_hi_reg, div_ovf_reg;
   logic [WIDTH-1:0] out_reg, out_hi_reg;
   logic             ovf_reg, dbz_reg;

   logic             is_iter, is_div, is_signed, div_zero, last_step;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sc_res, a_mag, b_mag;
   logic             sc_ovf;

   assign shamt     = in_1[SHW-1:0];
   assign is_div    = (op == OP_DIVU) || (op == OP_DIVS);
   assign is_iter   = (op == OP_MULU) || (op == OP_MULS) || is_div;
   assign is_signed = (op == OP_MULS) || (op == OP_DIVS);
   assign div_zero  = is_div && (in_1 == '0);
   assign last_step = (state_reg == BUSY) && (cnt_reg == SHW'(WIDTH - 1));
   assign a_mag     = (is_signed && in_0[WIDTH-1]) ? -in_0 : in_0;
   assign b_mag     = (is_signed && in_1[WIDTH-1]) ? -in_1 : in_1;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic; flush overrides both accept and consume
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (in_valid) state_next = (is_iter && !div_zero) ? BUSY : DONE;
         BUSY: if (last_step) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Output logic
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   assign out         = out_reg;
   assign out_hi      = out_hi_reg;
   assign overflow    = ovf_reg;
   assign div_by_zero = dbz_reg;

   always_comb begin
      sc_res = in_0;
      sc_ovf = 1'b0;
      case (op)
         OP_AND:  sc_res = in_0 & in_1;
         OP_OR:   sc_res = in_0 | in_1;
         OP_XOR:  sc_res = in_0 ^ in_1;
         OP_ADDS: begin
            sc_res = in_0 + in_1;
            sc_ovf = (in_0[WIDTH-1] == in_1[WIDTH-1]) && (sc_res[WIDTH-1] != in_0[WIDTH-1]);
         end
         OP_ADDU: sc_res = in_0 + in_1;
         OP_SUBS: begin
            sc_res = in_0 - in_1;
            sc_ovf = (in_0[WIDTH-1] != in_1[WIDTH-1]) && (sc_res[WIDTH-1] != in_0[WIDTH-1]);
         end
         OP_SUBU: sc_res = in_0 - in_1;
         OP_SHRL: sc_res = in_0 >> shamt;
         OP_SHLL: sc_res = in_0 << shamt;
         OP_SHRA: sc_res = $signed(in_0) >>> shamt;
         default: sc_res = in_0;
      endcase
   end

   // One multiply or divide iteration, plus sign correction for the final step
   logic [WIDTH:0]     add_sum, div_shift, div_diff;
   logic [WIDTH-1:0]   acc_step, mq_step, fin_lo, fin_hi;
   logic [2*WIDTH-1:0] prod;
   logic               fin_ovf, step_div;

   assign step_div = (op_reg == OP_DIVU) || (op_reg == OP_DIVS);

   always_comb begin
      add_sum   = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, mag_reg} : '0);
      div_shift = {acc_reg, mq_reg[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_reg};
      prod      = '0;
      if (step_div) begin
         acc_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
         mq_step  = {mq_reg[WIDTH-2:0], ~div_diff[WIDTH]};
         fin_lo   = neg_lo_reg ? -mq_step : mq_step;
         fin_hi   = neg_hi_reg ? -acc_step : acc_step;
      end else begin
         acc_step = add_sum[WIDTH:1];
         mq_step  = {add_sum[0], mq_reg[WIDTH-1:1]};
         prod     = {acc_step, mq_step};
         if (neg_lo_reg) prod = -prod;
         fin_lo   = prod[WIDTH-1:0];
         fin_hi   = prod[2*WIDTH-1:WIDTH];
      end
      case (op_reg)
         OP_MULU: fin_ovf = (fin_hi != '0);
         OP_MULS: fin_ovf = (fin_hi != {WIDTH{fin_lo[WIDTH-1]}});
         OP_DIVS: fin_ovf = div_ovf_reg;
         default: fin_ovf = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_reg      <= OP_PASS;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         mq_reg      <= '0;
         mag_reg     <= '0;
         neg_lo_reg  <= 1'b0;
         neg_hi_reg  <= 1'b0;
         div_ovf_reg <= 1'b0;
         out_reg     <= '0;
         out_hi_reg  <= '0;
         ovf_reg     <= 1'b0;
         dbz_reg     <= 1'b0;
      end else if (flush) begin
         cnt_reg <= '0;
         ovf_reg <= 1'b0;
         dbz_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (in_valid) begin
               op_reg  <= op;
               cnt_reg <= '0;
               if (div_zero) begin
                  out_reg    <= '1;
                  out_hi_reg <= in_0;
                  ovf_reg    <= 1'b0;
                  dbz_reg    <= 1'b1;
               end else if (is_iter) begin
                  acc_reg     <= '0;
                  mq_reg      <= is_div ? a_mag : b_mag;
                  mag_reg     <= is_div ? b_mag : a_mag;
                  neg_lo_reg  <= is_signed && (in_0[WIDTH-1] ^ in_1[WIDTH-1]);
                  neg_hi_reg  <= is_signed && in_0[WIDTH-1];
                  div_ovf_reg <= (op == OP_DIVS) && (in_0 == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (in_1 == '1);
                  ovf_reg     <= 1'b0;
                  dbz_reg     <= 1'b0;
               end else begin
                  out_reg    <= sc_res;
                  out_hi_reg <= '0;
                  ovf_reg    <= sc_ovf;
                  dbz_reg    <= 1'b0;
               end
            end
            BUSY: begin
               acc_reg <= acc_step;
               mq_reg  <= mq_step;
               cnt_reg <= cnt_reg + SHW'(1);
               if (last_step) begin
                  out_reg    <= fin_lo;
                  out_hi_reg <= fin_hi;
                  ovf_reg    <= fin_ovf;
                  dbz_reg    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
